// File: rtl/maze_pkg.sv
// Shared widths, action encodings and FSM state type for the maze environment.
package maze_pkg;

  localparam int STATE_W  = 6;
  localparam int REWARD_W = 16;

  localparam logic [1:0] ACT_UP    = 2'd0;
  localparam logic [1:0] ACT_RIGHT = 2'd1;
  localparam logic [1:0] ACT_DOWN  = 2'd2;
  localparam logic [1:0] ACT_LEFT  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } fsm_t;

endpackage

// File: rtl/maze_move_calc.sv
// Combinational move evaluation: target cell, reward and terminal flag
// for one action taken from pos on the 8x8 grid.
module maze_move_calc
  import maze_pkg::*;
#(
  parameter logic [STATE_W-1:0]         GOAL_STATE = 6'd63,
  parameter logic [63:0]                WALL_MAP   = 64'h0,
  parameter logic [63:0]                TRAP_MAP   = 64'h0,
  parameter logic signed [REWARD_W-1:0] R_GOAL     = 16'sd100,
  parameter logic signed [REWARD_W-1:0] R_TRAP     = -16'sd50,
  parameter logic signed [REWARD_W-1:0] R_WALL     = -16'sd10,
  parameter logic signed [REWARD_W-1:0] R_STEP     = -16'sd1
) (
  input  logic [STATE_W-1:0]         pos,
  input  logic [1:0]                 action,
  output logic [STATE_W-1:0]         target,
  output logic signed [REWARD_W-1:0] reward,
  output logic                       terminal
);

  logic [2:0]         row, col, nrow, ncol;
  logic               off_grid;
  logic [STATE_W-1:0] tgt;

  // Raw neighbour cell, then the priority rules: blocked, goal, trap, plain step
  always_comb begin
    row      = pos[5:3];
    col      = pos[2:0];
    nrow     = row;
    ncol     = col;
    off_grid = 1'b0;
    case (action)
      ACT_UP:    if (row == 3'd0) off_grid = 1'b1; else nrow = row - 3'd1;
      ACT_RIGHT: if (col == 3'd7) off_grid = 1'b1; else ncol = col + 3'd1;
      ACT_DOWN:  if (row == 3'd7) off_grid = 1'b1; else nrow = row + 3'd1;
      default:   if (col == 3'd0) off_grid = 1'b1; else ncol = col - 3'd1;
    endcase
    tgt = {nrow, ncol};

    target   = tgt;
    reward   = R_STEP;
    terminal = 1'b0;
    if (off_grid || WALL_MAP[tgt]) begin
      // Bumps leave the agent in place
      target = pos;
      reward = R_WALL;
    end else if (tgt == GOAL_STATE) begin
      reward   = R_GOAL;
      terminal = 1'b1;
    end else if (TRAP_MAP[tgt]) begin
      reward   = R_TRAP;
      terminal = 1'b1;
    end
  end

endmodule

// File: rtl/maze_env_responder.sv
// Maze environment responder: takes one action per 3 cycles and reports
// the transition with a fixed 2-cycle handshake-to-response latency.
module maze_env_responder
  import maze_pkg::*;
#(
  parameter logic [STATE_W-1:0]         START_STATE = 6'd0,
  parameter logic [STATE_W-1:0]         GOAL_STATE  = 6'd63,
  parameter logic [63:0]                WALL_MAP    = 64'h0,
  parameter logic [63:0]                TRAP_MAP    = 64'h0,
  parameter logic [15:0]                MAX_STEPS   = 16'd255,
  parameter logic signed [REWARD_W-1:0] R_GOAL      = 16'sd100,
  parameter logic signed [REWARD_W-1:0] R_TRAP      = -16'sd50,
  parameter logic signed [REWARD_W-1:0] R_WALL      = -16'sd10,
  parameter logic signed [REWARD_W-1:0] R_STEP      = -16'sd1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       act_valid,
  output logic                       act_ready,
  input  logic [1:0]                 action,
  output logic                       resp_valid,
  output logic [STATE_W-1:0]         state,
  output logic [STATE_W-1:0]         next_state,
  output logic signed [REWARD_W-1:0] reward,
  output logic                       done,
  output logic [15:0]                step_cnt,
  output logic [15:0]                episode_cnt
);

  fsm_t                       fsm_q, fsm_d;
  logic [1:0]                 act_q, act_d;
  logic [STATE_W-1:0]         pos_q, pos_d;
  logic [STATE_W-1:0]         state_q, state_d;
  logic [STATE_W-1:0]         nst_q, nst_d;
  logic signed [REWARD_W-1:0] rew_q, rew_d;
  logic                       done_q, done_d;
  logic [15:0]                step_q, step_d;
  logic [15:0]                ep_q, ep_d;

  logic [STATE_W-1:0]         calc_target;
  logic signed [REWARD_W-1:0] calc_reward;
  logic                       calc_term;

  maze_move_calc #(
    .GOAL_STATE(GOAL_STATE),
    .WALL_MAP  (WALL_MAP),
    .TRAP_MAP  (TRAP_MAP),
    .R_GOAL    (R_GOAL),
    .R_TRAP    (R_TRAP),
    .R_WALL    (R_WALL),
    .R_STEP    (R_STEP)
  ) u_calc (
    .pos     (pos_q),
    .action  (act_q),
    .target  (calc_target),
    .reward  (calc_reward),
    .terminal(calc_term)
  );

  // Next-state logic: latch action, capture transition on entering RESP, commit in RESP
  always_comb begin
    fsm_d   = fsm_q;
    act_d   = act_q;
    pos_d   = pos_q;
    state_d = state_q;
    nst_d   = nst_q;
    rew_d   = rew_q;
    done_d  = done_q;
    step_d  = step_q;
    ep_d    = ep_q;
    case (fsm_q)
      IDLE: begin
        if (act_valid) begin
          act_d = action;
          fsm_d = CALC;
        end
      end
      CALC: begin
        state_d = pos_q;
        nst_d   = calc_target;
        rew_d   = calc_reward;
        // Timeout forces done but keeps the move's own reward
        done_d  = calc_term | ((step_q + 16'd1) == MAX_STEPS);
        fsm_d   = RESP;
      end
      RESP: begin
        fsm_d = IDLE;
        if (done_q) begin
          pos_d  = START_STATE;
          step_d = 16'd0;
          ep_d   = ep_q + 16'd1;
        end else begin
          pos_d  = nst_q;
          step_d = step_q + 16'd1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // State registers with synchronous reset that overrides any in-flight action
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      act_q   <= 2'd0;
      pos_q   <= START_STATE;
      state_q <= '0;
      nst_q   <= '0;
      rew_q   <= '0;
      done_q  <= 1'b0;
      step_q  <= 16'd0;
      ep_q    <= 16'd0;
    end else begin
      fsm_q   <= fsm_d;
      act_q   <= act_d;
      pos_q   <= pos_d;
      state_q <= state_d;
      nst_q   <= nst_d;
      rew_q   <= rew_d;
      done_q  <= done_d;
      step_q  <= step_d;
      ep_q    <= ep_d;
    end
  end

  assign act_ready   = (fsm_q == IDLE);
  assign resp_valid  = (fsm_q == RESP);
  assign state       = state_q;
  assign next_state  = nst_q;
  assign reward      = rew_q;
  assign done        = done_q;
  assign step_cnt    = step_q;
  assign episode_cnt = ep_q;

endmodule

// File: tb/tb_maze_env_responder.sv
// Directed bench: three responder instances (open grid, walls/trap, short timeout).
module tb_maze_env_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  act_valid, act_ready, resp_valid, done;
  logic [1:0]  action      [3];
  logic [5:0]  state       [3];
  logic [5:0]  next_state  [3];
  logic [15:0] reward      [3];
  logic [15:0] step_cnt    [3];
  logic [15:0] episode_cnt [3];

  maze_env_responder u0 (
    .clk(clk), .rst(rst), .act_valid(act_valid[0]), .act_ready(act_ready[0]),
    .action(action[0]), .resp_valid(resp_valid[0]), .state(state[0]),
    .next_state(next_state[0]), .reward(reward[0]), .done(done[0]),
    .step_cnt(step_cnt[0]), .episode_cnt(episode_cnt[0])
  );

  maze_env_responder #(.WALL_MAP(64'h2), .TRAP_MAP(64'h100)) u1 (
    .clk(clk), .rst(rst), .act_valid(act_valid[1]), .act_ready(act_ready[1]),
    .action(action[1]), .resp_valid(resp_valid[1]), .state(state[1]),
    .next_state(next_state[1]), .reward(reward[1]), .done(done[1]),
    .step_cnt(step_cnt[1]), .episode_cnt(episode_cnt[1])
  );

  maze_env_responder #(.MAX_STEPS(16'd3)) u2 (
    .clk(clk), .rst(rst), .act_valid(act_valid[2]), .act_ready(act_ready[2]),
    .action(action[2]), .resp_valid(resp_valid[2]), .state(state[2]),
    .next_state(next_state[2]), .reward(reward[2]), .done(done[2]),
    .step_cnt(step_cnt[2]), .episode_cnt(episode_cnt[2])
  );

  typedef struct {
    int          u;
    logic [1:0]  a;
    logic [5:0]  s;
    logic [5:0]  ns;
    logic [15:0] rw;
    logic        d;
    logic [15:0] st;
    logic [15:0] ep;
  } vec_t;

  int errs = 0;
  int checks = 0;

  int          r_lat;
  logic        r_pulse2;
  logic [5:0]  r_state, r_next;
  logic [15:0] r_rew, r_step, r_ep;
  logic        r_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Offer one action on unit u from a negedge; capture the response and the
  // counters one cycle after the pulse. Returns on a negedge.
  task automatic do_act(input int u, input logic [1:0] a);
    int n;
    action[u] = a;
    act_valid[u] = 1'b1;
    n = 0;
    while (!act_ready[u] && n < 10) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    act_valid[u] = 1'b0;
    n = 1;
    while (!resp_valid[u] && n < 10) begin @(negedge clk); n++; end
    r_lat   = n;
    r_state = state[u];
    r_next  = next_state[u];
    r_rew   = reward[u];
    r_done  = done[u];
    @(negedge clk);
    r_pulse2 = resp_valid[u];
    r_step   = step_cnt[u];
    r_ep     = episode_cnt[u];
  endtask

  task automatic chk_resp(input string tag, input vec_t v);
    chk({tag, " latency"}, r_lat, 2);
    chk({tag, " pulse_width"}, {31'd0, r_pulse2}, 0);
    chk({tag, " state"}, {26'd0, r_state}, {26'd0, v.s});
    chk({tag, " next_state"}, {26'd0, r_next}, {26'd0, v.ns});
    chk({tag, " reward"}, {16'd0, r_rew}, {16'd0, v.rw});
    chk({tag, " done"}, {31'd0, r_done}, {31'd0, v.d});
    chk({tag, " step_cnt"}, {16'd0, r_step}, {16'd0, v.st});
    chk({tag, " episode_cnt"}, {16'd0, r_ep}, {16'd0, v.ep});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [13];
    vec_t v;
    int   pulses;

    // unit 0: open grid
    tbl[0]  = '{0, 2'd1, 6'd0, 6'd1, -16'sd1,  1'b0, 16'd1, 16'd0};
    tbl[1]  = '{0, 2'd0, 6'd1, 6'd1, -16'sd10, 1'b0, 16'd2, 16'd0};
    tbl[2]  = '{0, 2'd3, 6'd1, 6'd0, -16'sd1,  1'b0, 16'd3, 16'd0};
    tbl[3]  = '{0, 2'd3, 6'd0, 6'd0, -16'sd10, 1'b0, 16'd4, 16'd0};
    // unit 1: wall at cell 1, trap at cell 8
    tbl[4]  = '{1, 2'd1, 6'd0, 6'd0, -16'sd10, 1'b0, 16'd1, 16'd0};
    tbl[5]  = '{1, 2'd2, 6'd0, 6'd8, -16'sd50, 1'b1, 16'd0, 16'd1};
    tbl[6]  = '{1, 2'd1, 6'd0, 6'd0, -16'sd10, 1'b0, 16'd1, 16'd1};
    // unit 2: MAX_STEPS = 3
    tbl[7]  = '{2, 2'd1, 6'd0, 6'd1, -16'sd1,  1'b0, 16'd1, 16'd0};
    tbl[8]  = '{2, 2'd1, 6'd1, 6'd2, -16'sd1,  1'b0, 16'd2, 16'd0};
    tbl[9]  = '{2, 2'd1, 6'd2, 6'd3, -16'sd1,  1'b1, 16'd0, 16'd1};
    tbl[10] = '{2, 2'd1, 6'd0, 6'd1, -16'sd1,  1'b0, 16'd1, 16'd1};
    tbl[11] = '{2, 2'd0, 6'd1, 6'd1, -16'sd10, 1'b0, 16'd2, 16'd1};
    tbl[12] = '{2, 2'd0, 6'd1, 6'd1, -16'sd10, 1'b1, 16'd0, 16'd2};

    rst = 1'b1;
    act_valid = 3'b000;
    for (int i = 0; i < 3; i++) action[i] = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst act_ready", {29'd0, act_ready}, 32'h7);
    chk("rst resp_valid", {29'd0, resp_valid}, 0);
    chk("rst state", {26'd0, state[0]}, 0);
    chk("rst next_state", {26'd0, next_state[0]}, 0);
    chk("rst reward", {16'd0, reward[0]}, 0);
    chk("rst done", {29'd0, done}, 0);
    chk("rst step_cnt", {16'd0, step_cnt[0]}, 0);
    chk("rst episode_cnt", {16'd0, episode_cnt[0]}, 0);

    for (int i = 0; i < 13; i++) begin
      v = tbl[i];
      do_act(v.u, v.a);
      chk_resp($sformatf("vec%0d", i), v);
    end

    // Walk unit 0 from cell 0 to cell 62: 7 downs then 6 rights
    for (int i = 0; i < 7; i++) do_act(0, 2'd2);
    for (int i = 0; i < 6; i++) do_act(0, 2'd1);
    chk("walk next_state", {26'd0, r_next}, 62);
    chk("walk step_cnt", {16'd0, r_step}, 17);

    v = '{0, 2'd1, 6'd62, 6'd63, 16'sd100, 1'b1, 16'd0, 16'd1};
    do_act(0, 2'd1);
    chk_resp("goal", v);
    v = '{0, 2'd1, 6'd0, 6'd1, -16'sd1, 1'b0, 16'd1, 16'd1};
    do_act(0, 2'd1);
    chk_resp("after_goal", v);

    // Reset during CALC with act_valid still held
    action[0] = 2'd2;
    act_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("calc act_ready", {31'd0, act_ready[0]}, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    act_valid[0] = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid[0]) pulses++;
      @(negedge clk);
    end
    chk("midrst resp pulses", pulses, 0);
    chk("midrst act_ready", {31'd0, act_ready[0]}, 1);
    chk("midrst step_cnt", {16'd0, step_cnt[0]}, 0);
    chk("midrst episode_cnt", {16'd0, episode_cnt[0]}, 0);
    chk("midrst episode_cnt u2", {16'd0, episode_cnt[2]}, 0);
    chk("midrst state", {26'd0, state[0]}, 0);
    chk("midrst reward", {16'd0, reward[0]}, 0);
    v = '{0, 2'd1, 6'd0, 6'd1, -16'sd1, 1'b0, 16'd1, 16'd0};
    do_act(0, 2'd1);
    chk_resp("post_rst", v);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
